seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
Time-multiplexed scan controller for a DIGITS-wide common-anode seven-segment bank. It sits directly upstream of the per-digit hex decoder: it selects one digit at a time, drives that digit's 4-bit nibble into the decoder, and asserts the matching active-low digit enable. Displayed values are double-buffered and only swap at frame boundaries, so a frame never shows digits from two different values. Optional leading-zero blanking is provided.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2).
CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
value  input  4*DIGITS  hex value to display; nibble i = value[4i+3:4i].
load  input  1  one-cycle strobe; captures value.
blank_lz  input  1  1 = blank leading-zero digits.
nibble  output  4  nibble of the currently selected digit; feeds the decoder.
digit_en  output  DIGITS  active-low one-hot digit enable.
frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - Prescaler = 0; digit index idx = 0.
  - Shadow register = 0; pending register = 0; pend_valid = 0.
  - nibble = 4'h0; digit_en = all ones (all digits off); frame_done = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then returns to 0.
  - Its terminal count (tc) advances idx modulo DIGITS.
  - wrap = tc when idx == DIGITS-1.
- Registered outputs:
  - nibble and digit_en are registered from the next-state idx and shadow. They change on the same edge that updates idx.
  - Exception: in the first cycle after reset release they take the digit-0 values (digit_en = ~1, nibble = shadow[3:0]).
  - No output glitches between digits.
- Exactly one digit_en bit is low at a time, except for blanked digits (see below).
- Double buffer:
  - load without wrap in the same cycle: pending <= value, pend_valid <= 1. When several loads arrive within one frame, the last one wins.
  - wrap with pend_valid=1: shadow <= pending, pend_valid <= 0.
  - load and wrap in the same cycle: shadow <= value directly, pend_valid <= 0. The stale pending value is discarded.
  - The new shadow value first appears on digit 0 of the next frame.
- frame_done: registered pulse, high for exactly one cycle on the edge where idx goes from DIGITS-1 to 0. It coincides with the first cycle of the new frame's digit 0.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i>=1) is blanked when shadow nibbles i..DIGITS-1 are all zero.
  - A blanked digit keeps its digit_en bit high (off) for its whole slot, but the scan timing is unchanged. nibble still carries the zero nibble.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - blank_lz is sampled every cycle; it takes effect at the next digit-slot boundary.
- Reset mid-frame immediately forces all outputs to their reset values and discards both the pending and the shadow contents.

Test Plan:
- Reset and scan (DIGITS=4, REFRESH_DIV=4, load 16'h1234 during reset-release frame) -> after the next frame_done: nibble sequence 4,3,2,1; digit_en sequence 1110,1101,1011,0111; each held exactly 4 clocks; frame_done period 16 clocks.
- Double buffer: load 16'hABCD mid-frame while 16'h1234 is displayed -> remaining digits still show 1234 nibbles; first nibble after frame_done = D, then C,B,A.
- Simultaneous load and wrap: pulse load with 16'h00F0 on the wrap cycle while a 16'h5555 load is pending -> next frame shows 0,F,0,0; 5555 is never displayed.
- Leading zeros: shadow 16'h0070 with blank_lz=1 -> digit_en slots: 1110, 1101, 1111, 1111. Same value with blank_lz=0 -> all four digits lit. Shadow 16'h0000 with blank_lz=1 -> only digit 0 lit, nibble 0.
- Async reset mid-scan: assert rst between clock edges while idx=2 -> digit_en=1111, nibble=0, frame_done=0 immediately, without waiting for a clock edge. After release the scan restarts at digit 0 and displays 0.
- Last-load-wins: three loads (16'h1111, 16'h2222, 16'h3333) inside one frame -> the next frame shows only 3,3,3,3.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for a common-anode seven-segment bank.
// Double-buffered display value, frame-aligned swaps, leading-zero blanking.
module seven_seg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [VAL_W-1:0]  shadow;
    logic [VAL_W-1:0]  shadow_nxt;
    logic [VAL_W-1:0]  pending;
    logic [VAL_W-1:0]  pending_nxt;
    logic              pend_valid;
    logic              pend_valid_nxt;
    logic              started;
    logic              tc;
    logic              wrap;
    logic              refresh;
    logic              zero_run;
    logic [DIGITS-1:0] blank;
    logic [DIGITS-1:0] sel;
    logic [DIGITS-1:0] en_nxt;
    logic [3:0]        nib_nxt;

    assign tc   = (presc == PRESC_LAST);
    assign wrap = tc && (idx == IDX_LAST);

    // Outputs refresh at every slot boundary, and once right after reset
    // so digit 0 lights without waiting a full slot.
    assign refresh = tc || !started;

    // Prescaler: counts one digit slot of REFRESH_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tc) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Next digit index: advance on terminal count, wrap after last digit.
    always_comb begin
        idx_nxt = idx;
        if (wrap) begin
            idx_nxt = '0;
        end else if (tc) begin
            idx_nxt = idx + 1'b1;
        end
    end

    // Digit index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end

    // Double buffer: a load on the wrap cycle bypasses pending entirely,
    // otherwise the latest load waits in pending until the frame wraps.
    always_comb begin
        shadow_nxt     = shadow;
        pending_nxt    = pending;
        pend_valid_nxt = pend_valid;
        if (load && wrap) begin
            shadow_nxt     = value;
            pend_valid_nxt = 1'b0;
        end else if (wrap && pend_valid) begin
            shadow_nxt     = pending;
            pend_valid_nxt = 1'b0;
        end else if (load) begin
            pending_nxt    = value;
            pend_valid_nxt = 1'b1;
        end
    end

    // Shadow and pending buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else begin
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            pend_valid <= pend_valid_nxt;
        end
    end

    // Leading-zero mask: digit i is blank when it and all higher nibbles
    // are zero; digit 0 always stays lit.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (shadow_nxt[4*i +: 4] == 4'h0);
            blank[i] = blank_lz && zero_run;
        end
    end

    // Next-state digit select and nibble for the output registers.
    always_comb begin
        sel     = DIGITS'(1) << idx_nxt;
        en_nxt  = ~(sel & ~blank);
        nib_nxt = shadow_nxt[4*idx_nxt +: 4];
    end

    // Marks that the first post-reset output load has happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Glitch-free registered outputs, updated only at slot boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nibble     <= 4'h0;
            digit_en   <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (refresh) begin
                nibble   <= nib_nxt;
                digit_en <= en_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (DIGITS=4, REFRESH_DIV=4).
// Reference model derives display state from the cycle count since reset.
module tb_seven_seg_scan;

    localparam int D  = 4;
    localparam int R  = 4;
    localparam int FR = D * R;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic        frame_done;

    int cmp;
    int errs;

    int          k;
    logic [15:0] m_sh;
    logic [15:0] m_pd;
    bit          m_pv;
    logic [3:0]  e_nib;
    logic [3:0]  e_en;
    logic        e_fd;

    seven_seg_scan #(
        .DIGITS(D),
        .REFRESH_DIV(R),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .load(load),
        .blank_lz(blank_lz),
        .nibble(nibble),
        .digit_en(digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        k     = 0;
        m_sh  = 16'h0;
        m_pd  = 16'h0;
        m_pv  = 1'b0;
        e_nib = 4'h0;
        e_en  = 4'hF;
        e_fd  = 1'b0;
    endtask

    // k = clock edges since reset release. Edge k starts digit (k/R)%D
    // when k is a multiple of R; edge 1 shows digit 0; multiples of FR wrap.
    task automatic model_edge(input bit ld, input logic [15:0] v,
                              input bit blz);
        int d;
        bit wr;
        k++;
        wr = (k % FR) == 0;
        if (ld && wr) begin
            m_sh = v;
            m_pv = 1'b0;
        end else if (wr && m_pv) begin
            m_sh = m_pd;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pd = v;
            m_pv = 1'b1;
        end
        e_fd = wr;
        if (k == 1 || (k % R) == 0) begin
            d     = (k / R) % D;
            e_nib = 4'((m_sh >> (4 * d)) & 16'hF);
            e_en  = 4'hF;
            if (!(blz && d >= 1 && (m_sh >> (4 * d)) == 16'h0))
                e_en[d] = 1'b0;
        end
    endtask

    task automatic tick(input bit ld, input logic [15:0] v);
        load  = ld;
        value = v;
        @(posedge clk);
        model_edge(ld, v, blank_lz);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] seq_nib [4];
        int s;
        seq_nib = '{4'h4, 4'h3, 4'h2, 4'h1};
        #12;
        cmp++;
        if (nibble !== 4'h0 || digit_en !== 4'hF || frame_done !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got nib=%h en=%b fd=%b, want 0 1111 0",
                     nibble, digit_en, frame_done);
        end
        rst = 1'b0;
        model_reset();
        tick(1'b1, 16'h1234);
        cmp++;
        if (nibble !== 4'h0 || digit_en !== 4'b1110) begin
            errs++;
            $display("FAIL first_cycle: got nib=%h en=%b, want 0 1110",
                     nibble, digit_en);
        end
        for (int i = 0; i < 2 * FR - 1; i++) begin
            tick(1'b0, 16'h0);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd) begin
                errs++;
                $display("FAIL scan k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
            if (k > FR) begin
                s = ((k - FR) % FR) / R;
                cmp++;
                if (nibble !== seq_nib[s] || digit_en !== ~(4'b0001 << s)
                    || frame_done !== ((k % FR) == 0)) begin
                    errs++;
                    $display("FAIL scan_1234 k=%0d: got %h %b %b, want %h %b",
                             k, nibble, digit_en, frame_done, seq_nib[s],
                             ~(4'b0001 << s));
                end
            end
        end
    endtask

    task automatic test_double_buffer();
        while ((k % FR) != 6) tick(1'b0, 16'h0);
        tick(1'b1, 16'hABCD);
        while ((k % FR) != 0) begin
            tick(1'b0, 16'h0);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd) begin
                errs++;
                $display("FAIL dbuf k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
        end
        cmp++;
        if (nibble !== 4'hD || frame_done !== 1'b1) begin
            errs++;
            $display("FAIL dbuf_swap: got nib=%h fd=%b, want D 1",
                     nibble, frame_done);
        end
        for (int i = 0; i < FR; i++) begin
            tick(1'b0, 16'h0);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd) begin
                errs++;
                $display("FAIL dbuf_frame k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        while ((k % FR) != 4) tick(1'b0, 16'h0);
        tick(1'b1, 16'h5555);
        while ((k % FR) != FR - 1) tick(1'b0, 16'h0);
        tick(1'b1, 16'h00F0);
        cmp++;
        if (nibble !== 4'h0 || digit_en !== 4'b1110 || frame_done !== 1'b1) begin
            errs++;
            $display("FAIL wrap_load: got %h %b %b, want 0 1110 1",
                     nibble, digit_en, frame_done);
        end
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, 16'h0);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd
                || nibble === 4'h5) begin
                errs++;
                $display("FAIL wrap_frame k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
        end
    endtask

    task automatic test_blank();
        logic [3:0] want_en [4];
        int s;
        want_en = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        tick(1'b1, 16'h0070);
        blank_lz = 1'b1;
        while ((k % FR) != 0) tick(1'b0, 16'h0);
        for (int i = 0; i < FR; i++) begin
            s = (k % FR) / R;
            cmp++;
            if (digit_en !== want_en[s] || nibble !== e_nib || digit_en !== e_en) begin
                errs++;
                $display("FAIL blank_0070 k=%0d: got en=%b nib=%h, want en=%b nib=%h",
                         k, digit_en, nibble, want_en[s], e_nib);
            end
            tick(1'b0, 16'h0);
        end
        blank_lz = 1'b0;
        for (int i = 0; i < FR; i++) begin
            tick(1'b0, 16'h0);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd
                || digit_en === 4'b1111) begin
                errs++;
                $display("FAIL noblank k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
        end
        tick(1'b1, 16'h0000);
        blank_lz = 1'b1;
        while ((k % FR) != 0) tick(1'b0, 16'h0);
        for (int i = 0; i < FR; i++) begin
            s = (k % FR) / R;
            cmp++;
            if (nibble !== 4'h0 || digit_en !== ((s == 0) ? 4'b1110 : 4'b1111)) begin
                errs++;
                $display("FAIL blank_zero k=%0d: got en=%b nib=%h", k,
                         digit_en, nibble);
            end
            tick(1'b0, 16'h0);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_async_reset();
        tick(1'b1, 16'h9876);
        while ((k % FR) != 9) tick(1'b0, 16'h0);
        #3;
        rst = 1'b1;
        #1;
        cmp++;
        if (nibble !== 4'h0 || digit_en !== 4'hF || frame_done !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: got %h %b %b, want 0 1111 0",
                     nibble, digit_en, frame_done);
        end
        #3;
        rst = 1'b0;
        model_reset();
        tick(1'b0, 16'h0);
        cmp++;
        if (nibble !== 4'h0 || digit_en !== 4'b1110) begin
            errs++;
            $display("FAIL restart: got nib=%h en=%b, want 0 1110",
                     nibble, digit_en);
        end
        for (int i = 0; i < FR + 2; i++) begin
            tick(1'b0, 16'h0);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd
                || nibble !== 4'h0) begin
                errs++;
                $display("FAIL after_reset k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
        end
    endtask

    task automatic test_last_load();
        while ((k % FR) != 1) tick(1'b0, 16'h0);
        tick(1'b1, 16'h1111);
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h2222);
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h3333);
        while ((k % FR) != 0) tick(1'b0, 16'h0);
        for (int i = 0; i < FR; i++) begin
            cmp++;
            if (nibble !== 4'h3 || nibble !== e_nib || digit_en !== e_en) begin
                errs++;
                $display("FAIL last_load k=%0d: got nib=%h en=%b, want 3 %b",
                         k, nibble, digit_en, e_en);
            end
            tick(1'b0, 16'h0);
        end
    endtask

    task automatic test_random();
        bit          ld;
        logic [15:0] v;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 5) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            tick(ld, v);
            cmp++;
            if (nibble !== e_nib || digit_en !== e_en || frame_done !== e_fd) begin
                errs++;
                $display("FAIL random k=%0d: got %h %b %b, want %h %b %b",
                         k, nibble, digit_en, frame_done, e_nib, e_en, e_fd);
            end
        end
    endtask

    initial begin
        cmp      = 0;
        errs     = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        blank_lz = 1'b0;
        model_reset();
        test_reset();
        test_double_buffer();
        test_load_on_wrap();
        test_blank();
        test_async_reset();
        test_last_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
